// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - opcodes, jump/branch flags and sequencer states
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_R_TYPE = 6'b000000;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_STOP   = 6'b111111;

  localparam logic [5:0] FN_JR     = 6'b001000;

  typedef enum logic [1:0] {
    JB_NONE   = 2'b00,
    JB_BRANCH = 2'b01,
    JB_JUMP   = 2'b10
  } jb_flag_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_HALT  = 2'b10
  } state_e;

  // Instructions whose operands are compared in ID, so they need EX/MEM results early.
  function automatic logic resolves_in_id(input logic [5:0] op, input logic [5:0] funct);
    return (op == OP_BEQ) || (op == OP_BNE) || ((op == OP_R_TYPE) && (funct == FN_JR));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - decode-side bundle between ID logic and the sequencer
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);

  logic [5:0]       id_op;
  logic [5:0]       id_funct;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_invalid_rt;
  logic [1:0]       id_jb_flag;
  logic             ex_mem_to_reg;
  logic             ex_reg_write;
  logic [4:0]       ex_wreg;
  logic             mem_mem_to_reg;
  logic [4:0]       mem_wreg;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             ctl_mux;
  logic             halted;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_op, id_funct, id_rs, id_rt, id_invalid_rt, id_jb_flag,
    output ex_mem_to_reg, ex_reg_write, ex_wreg, mem_mem_to_reg, mem_wreg,
    input  pc_write, ifid_write, ifid_flush, ctl_mux, halted, stall_count
  );

  modport slave (
    input  id_op, id_funct, id_rs, id_rt, id_invalid_rt, id_jb_flag,
    input  ex_mem_to_reg, ex_reg_write, ex_wreg, mem_mem_to_reg, mem_wreg,
    output pc_write, ifid_write, ifid_flush, ctl_mux, halted, stall_count
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// rtl/pipeline_hazard_ctrl_hazard_detect.sv - combinational load-use and branch-operand hazard detection
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [5:0] i_id_op,
  input  logic [5:0] i_id_funct,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_invalid_rt,
  input  logic       i_ex_mem_to_reg,
  input  logic       i_ex_reg_write,
  input  logic [4:0] i_ex_wreg,
  input  logic       i_mem_mem_to_reg,
  input  logic [4:0] i_mem_wreg,
  output logic       o_lu_haz,
  output logic       o_br_haz
);

  // $0 is never a real dependency; rt only counts when the decoder says it is read.
  function automatic logic src_hit(input logic [4:0] r, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic invalid_rt);
    return (r != 5'd0) && ((r == rs) || (!invalid_rt && (r == rt)));
  endfunction

  logic w_ex_hit;
  logic w_mem_hit;

  assign w_ex_hit  = src_hit(i_ex_wreg,  i_id_rs, i_id_rt, i_id_invalid_rt);
  assign w_mem_hit = src_hit(i_mem_wreg, i_id_rs, i_id_rt, i_id_invalid_rt);

  assign o_lu_haz = i_ex_mem_to_reg && w_ex_hit;
  assign o_br_haz = resolves_in_id(i_id_op, i_id_funct) &&
                    ((i_ex_reg_write && w_ex_hit) || (i_mem_mem_to_reg && w_mem_hit));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - front-end sequencer: stall, flush and drain-to-halt on STOP
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int                 DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  state_e             r_state;
  state_e             w_next_state;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [DRAIN_W-1:0] w_next_drain;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic               w_lu_haz;
  logic               w_br_haz;
  logic               w_is_stop;
  logic               w_stall;
  logic               w_count_stall;
  logic               w_pc_write;
  logic               w_ifid_write;
  logic               w_ifid_flush;
  logic               w_ctl_mux;

  hazard_detect u_hazard_detect (
    .i_id_op          (bus.id_op),
    .i_id_funct       (bus.id_funct),
    .i_id_rs          (bus.id_rs),
    .i_id_rt          (bus.id_rt),
    .i_id_invalid_rt  (bus.id_invalid_rt),
    .i_ex_mem_to_reg  (bus.ex_mem_to_reg),
    .i_ex_reg_write   (bus.ex_reg_write),
    .i_ex_wreg        (bus.ex_wreg),
    .i_mem_mem_to_reg (bus.mem_mem_to_reg),
    .i_mem_wreg       (bus.mem_wreg),
    .o_lu_haz         (w_lu_haz),
    .o_br_haz         (w_br_haz)
  );

  assign w_is_stop = (bus.id_op == OP_STOP);
  assign w_stall   = (w_lu_haz || w_br_haz) && !w_is_stop;

  always_comb begin
    w_next_state  = r_state;
    w_next_drain  = r_drain_cnt;
    w_count_stall = 1'b0;
    w_pc_write    = 1'b0;
    w_ifid_write  = 1'b0;
    w_ifid_flush  = 1'b0;
    w_ctl_mux     = 1'b1;
    case (r_state)
      ST_RUN: begin
        if (w_is_stop) begin
          w_next_state = (DRAIN_CYCLES > 1) ? ST_DRAIN : ST_HALT;
          w_next_drain = DRAIN_LOAD;
        end else if (w_stall) begin
          w_count_stall = 1'b1;
        end else begin
          w_pc_write   = 1'b1;
          w_ifid_write = 1'b1;
          w_ctl_mux    = 1'b0;
          w_ifid_flush = (bus.id_jb_flag != JB_NONE);
        end
      end
      // Leave on the edge that would take the count to zero so halted lands DRAIN_CYCLES edges after STOP.
      ST_DRAIN: begin
        if (r_drain_cnt <= DRAIN_W'(1)) begin
          w_next_state = ST_HALT;
        end else begin
          w_next_drain = r_drain_cnt - DRAIN_W'(1);
        end
      end
      default: begin
      end
    endcase
    if (!reset) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_ifid_flush = 1'b0;
      w_ctl_mux    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_drain_cnt <= w_next_drain;
      if (w_count_stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.pc_write    = w_pc_write;
  assign bus.ifid_write  = w_ifid_write;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.ctl_mux     = w_ctl_mux;
  assign bus.halted      = (r_state == ST_HALT);
  assign bus.stall_count = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - vector table, directed sequences and randomized model check
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int CNT_W = 4;
  localparam int DRAIN = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int R     = 0;
  localparam int BEQ   = 4;
  localparam int BNE   = 5;
  localparam int J     = 2;
  localparam int JAL   = 3;
  localparam int ADDI  = 8;
  localparam int STOP  = 63;
  localparam int ADD   = 32;
  localparam int JR    = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) u_if ();

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       inv_rt;
    logic [1:0] jb;
    logic       ex_m2r;
    logic       ex_rw;
    logic [4:0] ex_wreg;
    logic       mem_m2r;
    logic [4:0] mem_wreg;
  } in_t;

  // exp = {pc_write, ifid_write, ifid_flush, ctl_mux}
  typedef struct {
    in_t        in;
    logic [3:0] exp;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   stop_age;
  int   m_cnt;
  vec_t tbl[15];
  in_t  idle;

  function automatic in_t mk(input int op, input int funct, input int rs, input int rt,
                             input int inv, input int jb, input int exm, input int exrw,
                             input int exw, input int memm, input int memw);
    in_t v;
    v.op = 6'(op); v.funct = 6'(funct); v.rs = 5'(rs); v.rt = 5'(rt);
    v.inv_rt = 1'(inv); v.jb = 2'(jb); v.ex_m2r = 1'(exm); v.ex_rw = 1'(exrw);
    v.ex_wreg = 5'(exw); v.mem_m2r = 1'(memm); v.mem_wreg = 5'(memw);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input in_t v);
    u_if.id_op = v.op; u_if.id_funct = v.funct; u_if.id_rs = v.rs; u_if.id_rt = v.rt;
    u_if.id_invalid_rt = v.inv_rt; u_if.id_jb_flag = v.jb;
    u_if.ex_mem_to_reg = v.ex_m2r; u_if.ex_reg_write = v.ex_rw; u_if.ex_wreg = v.ex_wreg;
    u_if.mem_mem_to_reg = v.mem_m2r; u_if.mem_wreg = v.mem_wreg;
  endtask

  function automatic logic [3:0] outs();
    return {u_if.pc_write, u_if.ifid_write, u_if.ifid_flush, u_if.ctl_mux};
  endfunction

  function automatic bit hit(input in_t v, input logic [4:0] r);
    return (r != 0) && ((r == v.rs) || (!v.inv_rt && (r == v.rt)));
  endfunction

  function automatic bit model_stall(input in_t v);
    bit lu, br, needs_ops;
    if (v.op == OP_STOP) return 1'b0;
    lu = v.ex_m2r && hit(v, v.ex_wreg);
    needs_ops = (v.op == OP_BEQ) || (v.op == OP_BNE) || ((v.op == OP_R_TYPE) && (v.funct == FN_JR));
    br = needs_ops && ((v.ex_rw && hit(v, v.ex_wreg)) || (v.mem_m2r && hit(v, v.mem_wreg)));
    return lu || br;
  endfunction

  // stop_age counts edges since STOP was accepted; the front end is frozen from then on.
  function automatic logic [3:0] model_out(input in_t v);
    if ((stop_age >= 1) || (v.op == OP_STOP)) return 4'b0001;
    if (model_stall(v)) return 4'b0001;
    if (v.jb != 2'b00) return 4'b1110;
    return 4'b1100;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    drive(idle);
    #1;
    chk("reset outs", 32'(outs()), 32'h1);
    chk("reset halted", 32'(u_if.halted), 32'h0);
    chk("reset count", 32'(u_if.stall_count), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    stop_age = -1;
    m_cnt = 0;
  endtask

  task automatic hand(input in_t v, input logic [3:0] exp, input int exp_halt,
                      input int exp_cnt, input string name);
    @(negedge clk);
    drive(v);
    #1;
    chk({name, " outs"}, 32'(outs()), 32'(exp));
    chk({name, " halted"}, 32'(u_if.halted), 32'(exp_halt));
    chk({name, " count"}, 32'(u_if.stall_count), 32'(exp_cnt));
    @(posedge clk);
  endtask

  task automatic model_cycle(input in_t v);
    @(negedge clk);
    drive(v);
    #1;
    chk("rand outs", 32'(outs()), 32'(model_out(v)));
    chk("rand halted", 32'(u_if.halted), 32'(stop_age >= DRAIN));
    chk("rand count", 32'(u_if.stall_count), 32'(m_cnt));
    @(posedge clk);
    if (stop_age >= 1) stop_age++;
    else if (v.op == OP_STOP) stop_age = 1;
    else if (model_stall(v)) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
  endtask

  function automatic in_t rnd();
    in_t v;
    int  k;
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    k = $urandom_range(0, 9);
    case (k)
      0, 1:    v.op = OP_R_TYPE;
      2:       v.op = OP_BEQ;
      3:       v.op = OP_BNE;
      4:       v.op = OP_J;
      5:       v.op = OP_JAL;
      6:       v.op = ($urandom_range(0, 19) == 0) ? OP_STOP : 6'b100011;
      default: v.op = 6'($urandom);
    endcase
    v.funct    = ($urandom_range(0, 1) == 1) ? FN_JR : 6'($urandom);
    v.rs       = 5'($urandom_range(0, 3));
    v.rt       = 5'($urandom_range(0, 3));
    v.inv_rt   = 1'($urandom_range(0, 1));
    v.jb       = 2'($urandom_range(0, 3));
    v.ex_m2r   = 1'($urandom_range(0, 1));
    v.ex_rw    = 1'($urandom_range(0, 1));
    v.ex_wreg  = 5'($urandom_range(0, 3));
    v.mem_m2r  = 1'($urandom_range(0, 1));
    v.mem_wreg = 5'($urandom_range(0, 3));
    return v;
  endfunction

  initial begin
    int   n_stall;
    in_t  lu;
    in_t  v;

    idle = mk(R, ADD, 8, 9, 0, 0, 0, 0, 0, 0, 0);
    lu   = mk(R, ADD, 2, 4, 0, 0, 1, 1, 2, 0, 0);

    tbl[0]  = '{mk(R,    ADD, 2, 4,  0, 0, 0, 0, 0,  0, 0), 4'b1100};
    tbl[1]  = '{mk(R,    ADD, 2, 4,  0, 0, 1, 1, 2,  0, 0), 4'b0001};
    tbl[2]  = '{mk(R,    ADD, 3, 2,  0, 0, 1, 1, 2,  0, 0), 4'b0001};
    tbl[3]  = '{mk(ADDI, 0,   3, 7,  1, 0, 1, 1, 7,  0, 0), 4'b1100};
    tbl[4]  = '{mk(R,    ADD, 0, 4,  0, 0, 1, 1, 0,  0, 0), 4'b1100};
    tbl[5]  = '{mk(BEQ,  0,   5, 6,  0, 1, 0, 1, 5,  0, 0), 4'b0001};
    tbl[6]  = '{mk(BEQ,  0,   5, 6,  0, 0, 0, 0, 0,  1, 6), 4'b0001};
    tbl[7]  = '{mk(R,    ADD, 2, 4,  0, 0, 0, 1, 2,  0, 0), 4'b1100};
    tbl[8]  = '{mk(BNE,  0,   5, 6,  0, 1, 0, 0, 0,  0, 0), 4'b1110};
    tbl[9]  = '{mk(J,    0,   0, 0,  1, 2, 0, 0, 0,  0, 0), 4'b1110};
    tbl[10] = '{mk(R,    JR, 31, 0,  1, 2, 0, 1, 31, 0, 0), 4'b0001};
    tbl[11] = '{mk(R,    ADD, 2, 4,  0, 0, 0, 0, 0,  1, 2), 4'b1100};
    tbl[12] = '{mk(BNE,  0,   5, 6,  0, 0, 0, 0, 0,  0, 6), 4'b1100};
    tbl[13] = '{mk(JAL,  0,   0, 0,  1, 2, 1, 1, 9,  0, 0), 4'b1110};
    tbl[14] = '{mk(BEQ,  0,   5, 6,  0, 1, 1, 1, 6,  0, 0), 4'b0001};

    reset = 1'b0;
    drive(idle);
    do_reset();

    n_stall = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(tbl[i].in);
      #1;
      chk($sformatf("vec%0d outs", i), 32'(outs()), 32'(tbl[i].exp));
      if (tbl[i].exp[0]) n_stall++;
      @(posedge clk);
    end
    @(negedge clk);
    drive(idle);
    #1;
    chk("vec stall total", 32'(u_if.stall_count), 32'(n_stall));

    do_reset();
    hand(lu, 4'b0001, 0, 0, "lu stall");
    hand(mk(R, ADD, 2, 4, 0, 0, 0, 0, 0, 1, 2), 4'b1100, 0, 1, "lu advance");

    do_reset();
    hand(mk(BEQ, 0, 5, 6, 0, 1, 1, 1, 5, 0, 0), 4'b0001, 0, 0, "beq ex load");
    hand(mk(BEQ, 0, 5, 6, 0, 1, 0, 0, 0, 1, 5), 4'b0001, 0, 1, "beq mem load");
    hand(mk(BEQ, 0, 5, 6, 0, 1, 0, 0, 0, 0, 0), 4'b1110, 0, 2, "beq redirect");
    hand(idle, 4'b1100, 0, 2, "beq after");

    do_reset();
    hand(mk(R, JR, 31, 0, 1, 2, 0, 1, 31, 0, 0), 4'b0001, 0, 0, "jr stall");
    hand(mk(R, JR, 31, 0, 1, 2, 0, 0, 0, 0, 31), 4'b1110, 0, 1, "jr redirect");

    do_reset();
    hand(mk(STOP, 0, 2, 4, 0, 1, 1, 1, 2, 0, 0), 4'b0001, 0, 0, "stop");
    hand(idle, 4'b0001, 0, 0, "drain1");
    hand(idle, 4'b0001, 0, 0, "drain2");
    hand(idle, 4'b0001, 1, 0, "halt");
    for (int i = 0; i < 4; i++) hand(rnd(), 4'b0001, 1, 0, "halt toggle");
    do_reset();
    hand(mk(STOP, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 4'b0001, 0, 0, "stop2");
    hand(idle, 4'b0001, 0, 0, "drain mid");
    do_reset();
    hand(idle, 4'b1100, 0, 0, "run after reset");

    do_reset();
    for (int i = 0; i < 20; i++) hand(lu, 4'b0001, 0, (i < CMAX) ? i : CMAX, "sat");
    hand(idle, 4'b1100, 0, CMAX, "sat hold");

    do_reset();
    for (int i = 0; i < 1500; i++) begin
      v = rnd();
      if ((stop_age >= DRAIN + 4) || ($urandom_range(0, 299) == 0)) do_reset();
      else model_cycle(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline sequencer for the 5-stage MIPS core, placed between the ID-stage decode logic and the PC / IF-ID / ID-EX registers. Each cycle it decides whether the front end advances, stalls, or is flushed:
- load-use and branch-operand stalls,
- ID-resolved jump/branch flushes,
- drain-and-halt on the STOP opcode.

It drives the bubble-select (`ctl_mux`) into the main decoder and keeps a saturating stall-cycle counter for performance checks.

## Interface
- `CNT_W`, default 16: width of the stall counter.
- `DRAIN_CYCLES`, default 3: cycles from STOP in ID until `halted` (covers the EX, MEM and WB drain).

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `id_op` in 6: ID-stage opcode.
- `id_funct` in 6: ID-stage funct field.
- `id_rs` in 5: ID-stage rs field.
- `id_rt` in 5: ID-stage rt field.
- `id_invalid_rt` in 1: rt is not a source operand (from the decoder).
- `id_jb_flag` in 2: 01 = branch taken, 10 = jump/jr, 00 = none.
- `ex_mem_to_reg` in 1: the EX-stage instruction is a load.
- `ex_reg_write` in 1: the EX-stage instruction writes a register.
- `ex_wreg` in 5: EX-stage destination register.
- `mem_mem_to_reg` in 1: the MEM-stage instruction is a load.
- `mem_wreg` in 5: MEM-stage destination register.
- `pc_write` out 1: PC load enable.
- `ifid_write` out 1: IF/ID register load enable.
- `ifid_flush` out 1: zero the IF/ID register on the next edge.
- `ctl_mux` out 1: force a bubble into ID/EX.
- `halted` out 1: pipeline drained; core stopped.
- `stall_count` out `CNT_W`: saturating count of stall cycles.

## Operation
- **FSM states:**
  - RUN: normal operation.
  - DRAIN: STOP is in ID; the front end is frozen while older instructions retire.
  - HALT: terminal; left only by reset.
- **Source match function:** `src_hit(r)` is true when `r != 0` and (`r == id_rs`, or `!id_invalid_rt` and `r == id_rt`).
- **Hazard conditions:**
  - `lu_haz` (load-use) = `ex_mem_to_reg && src_hit(ex_wreg)`.
  - `br_haz` applies only when ID holds BEQ, BNE, or R-type with funct JR. It is true when `(ex_reg_write && src_hit(ex_wreg)) || (mem_mem_to_reg && src_hit(mem_wreg))`.
  - `stall` = `lu_haz || br_haz`. Opcode STOP (111111) is never checked for hazards.
- **RUN, stall:** `pc_write=0`, `ifid_write=0`, `ctl_mux=1`, `ifid_flush=0`, `stall_count` +1.
- **RUN, no stall, `id_jb_flag != 00`:** `pc_write=1`, `ifid_write=1`, `ifid_flush=1`, `ctl_mux=0`.
- **RUN, no stall, no redirect:** `pc_write=1`, `ifid_write=1`, `ifid_flush=0`, `ctl_mux=0`.
- **STOP in ID (from RUN):**
  - Outputs this cycle: `pc_write=0`, `ifid_write=0`, `ctl_mux=1`.
  - Next state is DRAIN; the drain counter is loaded with `DRAIN_CYCLES-1`.
- **DRAIN:** outputs as in the STOP cycle; no stall counting. When the counter reaches 0, go to HALT.
- **HALT:** `halted=1`, `pc_write=0`, `ifid_write=0`, `ctl_mux=1`, `ifid_flush=0`. All inputs are ignored.
- **Priority:**
  1. Reset.
  2. HALT/DRAIN.
  3. STOP.
  4. Stall. A stall suppresses `ifid_flush`, because the branch is not yet resolved with stale operands.
  5. Redirect.
- **`stall_count`:** saturates at `2^CNT_W - 1`; it never wraps.

## Timing
- **Hazard and redirect outputs:** combinational from the current-cycle inputs and the registered state. Zero latency.
- **State, drain counter and `stall_count`:** registered.
- **Stall lengths:**
  - Load-use: exactly 1 stall cycle. The next cycle EX holds the bubble, so `lu_haz` clears.
  - Branch/JR after an ALU producer: 1 cycle.
  - Branch/JR after a load: 2 cycles (first the EX hit, then the MEM hit).
- **`halted`:** asserted on the edge `DRAIN_CYCLES` cycles after the STOP-in-ID cycle.
- **Reset asserted (asynchronous):**
  - State RUN, drain counter 0, `stall_count` 0.
  - Outputs: `pc_write=0`, `ifid_write=0`, `ctl_mux=1`, `ifid_flush=0`, `halted=0`.
- **Reset deasserted:** normal RUN behaviour from the first edge.
- **Reset mid-DRAIN or in HALT:** immediately returns to RUN with a cleared count.

## Structure
- **Package `pipe_ctrl_pkg`:**
  - Opcode constants: R_TYPE, J, JAL, BEQ, BNE, STOP.
  - Funct constant JR.
  - JBFlag encodings.
  - State encoding RUN/DRAIN/HALT.
- **Sub-module `hazard_detect`:** purely combinational computation of `lu_haz` and `br_haz`. The top level holds the FSM, the drain counter and the stall counter.

## Test plan
- **Load-use:** EX `lw $2` (`ex_mem_to_reg=1`, `ex_wreg=2`); ID `add $3,$2,$4` -> one cycle with `pc_write=0`, `ctl_mux=1`; `stall_count` 0->1; the next cycle advances.
- **Branch after load:** `lw $5`, then `beq $5,$6` in ID -> 2 stall cycles, then `id_jb_flag=01` -> `ifid_flush=1` for 1 cycle; `stall_count`=2.
- **Non-source rt and $0:**
  - `id_invalid_rt=1`, `ex_wreg=id_rt=7`, EX load -> no stall.
  - `ex_wreg=0` matching `rs=0` -> no stall.
- **Stall beats redirect:** `jr $31` with `ex_reg_write=1`, `ex_wreg=31`, `id_jb_flag=10` -> `ifid_flush=0` and a stall. The next cycle (no hazard) -> `ifid_flush=1`.
- **STOP:**
  - STOP in ID -> `pc_write=0` from that cycle; `halted=1` exactly 3 edges later.
  - Inputs toggling in HALT -> no output change.
  - `reset=0` -> `halted=0` asynchronously.
- **Counter saturation:** `CNT_W=4`, 20 consecutive load-use stalls -> `stall_count` holds 15.
